vec_mem_stage: RTL and testbench
================================

Name: vec_mem_stage

Overview:
- Memory stage directly downstream of the 6-lane vector execute datapath.
- Consumes the execute bundle: result vector, store vector, regWrite/memToReg/memWrite/PCSrc, destination register.
- Serialises vector loads and stores over a byte-wide synchronous data memory, one lane per cycle, stalling upstream stages while busy.
- Registers the completed bundle toward writeback.

Parameters:
- NLANES, 6: vector lanes; vector width is NLANES*LANE_W.
- LANE_W, 8: lane and memory data width.
- ADDR_W, 16: data memory address width.
- RA_W, 4: register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- regWriteE  in  1  execute-stage register write enable.
- memToRegE  in  1  execute-stage load indicator.
- memWriteE  in  1  execute-stage store indicator.
- PCSrcE  in  1  execute-stage PC redirect.
- WA3E  in  RA_W  execute-stage destination register.
- aluResultE  in  NLANES*LANE_W  post-ALU result; bits [ADDR_W-1:0] form the base address.
- writeDataE  in  NLANES*LANE_W  store vector; lane i is bits [8i+7:8i].
- mem_addr  out  ADDR_W  data memory address.
- mem_wdata  out  LANE_W  store byte.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe; mem_rdata is valid one cycle later.
- mem_rdata  in  LANE_W  read byte.
- stallM  out  1  freezes fetch/decode/execute while high.
- regWriteW, memToRegW, PCSrcW  out  1 each  writeback controls.
- WA3W  out  RA_W  writeback destination register.
- aluResultW  out  NLANES*LANE_W  registered result vector.
- readDataW  out  NLANES*LANE_W  assembled load vector.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, lane=0, all outputs 0, captured registers cleared.
- Reset mid-operation aborts immediately: mem_we/mem_re drop and no further memory writes occur.
- States: IDLE, STORE, LOAD, LOAD_TAIL. stallM = (state != IDLE), combinational.
- IDLE, no memory op (memWriteE=0 and memToRegE=0):
  - Next edge loads all W outputs from the E bundle; readDataW <= 0.
  - Latency is 1 cycle.
- IDLE, memWriteE=1: capture base=aluResultE[ADDR_W-1:0], writeDataE and the controls; go to STORE with lane=0.
  - memWriteE has priority if memToRegE is also 1; memToRegW is then forced 0.
- IDLE, memToRegE=1 (no store): capture and go to LOAD with lane=0.
- Entering any busy state, the W outputs take a bubble: regWriteW=PCSrcW=memToRegW=0 until completion.
- E inputs are ignored in all busy states; upstream holds the next instruction.
- STORE:
  - Per cycle: mem_we=1, mem_addr=base+lane (mod 2^ADDR_W), mem_wdata=lane byte; lane increments.
  - On lane==NLANES-1: next edge loads the W outputs from the captured bundle and returns to IDLE.
  - Occupancy is NLANES cycles.
- LOAD:
  - Per cycle: mem_re=1, mem_addr=base+lane; mem_rdata is written into readData lane (lane-1) when lane>0.
  - On lane==NLANES-1, go to LOAD_TAIL.
- LOAD_TAIL:
  - mem_re=0; mem_rdata is captured into lane NLANES-1.
  - W outputs are loaded, readDataW = assembled vector, return to IDLE.
  - Occupancy is NLANES+1 cycles.
- mem_addr, mem_wdata = 0 and mem_we = mem_re = 0 whenever not driven by STORE/LOAD.
- Address wraps modulo 2^ADDR_W; no error is flagged.
- Back-to-back memory ops: the second op is accepted on the first IDLE cycle after completion, with no dead cycle beyond that.

Decomposition:
- Shared package vec_pkg: NLANES, LANE_W, ADDR_W, RA_W, and the state enum mem_state_t.
- One natural sub-module, lane_sequencer: lane counter, wrap-around address adder, and last-lane detect.
- The FSM and W registers stay in vec_mem_stage.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, stallM=0. Assert rst=0 mid-STORE at lane 3 -> mem_we=0 immediately and addresses base+3..5 remain unwritten.
- ALU passthrough: regWriteE=1, WA3E=5, aluResultE=0x0000_0000_00AB -> next cycle regWriteW=1, WA3W=5, aluResultW=0xAB, stallM stays 0.
- Store: base 0x0100, writeDataE=0x665544332211 -> bytes 0x11..0x66 written at 0x0100..0x0105 over 6 cycles; stallM high exactly 6 cycles; W bubble until completion.
- Load: memory 0x0200..0x0205 preloaded 0xA0..0xA5 -> readDataW=0xA5A4A3A2A1A0 and memToRegW=1 after 7 stall cycles.
- Wrap: store at base 0xFFFE -> writes at 0xFFFE, 0xFFFF, 0x0000..0x0003.
- Back-to-back: store immediately followed by load of the same base -> load returns the stored vector, with no lost or duplicated writeback.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants and state encoding for the vector memory stage.
package vec_pkg;

  localparam int NLANES     = 6;
  localparam int LANE_W     = 8;
  localparam int ADDR_W     = 16;
  localparam int RA_W       = 4;
  localparam int VEC_W      = NLANES * LANE_W;
  localparam int LANE_IDX_W = $clog2(NLANES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STORE     = 2'd1,
    LOAD      = 2'd2,
    LOAD_TAIL = 2'd3
  } mem_state_t;

endpackage

// File: rtl/lane_sequencer.sv
// Lane counter for serialised vector memory access: current lane,
// wrap-around byte address and last-lane flag.
module lane_sequencer
  import vec_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  input  logic [ADDR_W-1:0]     base,
  output logic [LANE_IDX_W-1:0] lane,
  output logic [ADDR_W-1:0]     addr,
  output logic                  last
);

  assign last = (lane == LANE_IDX_W'(NLANES - 1));
  // Plain modular add: addresses past the top of memory wrap to zero.
  assign addr = base + ADDR_W'(lane);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= '0;
    end else if (step && !last) begin
      lane <= lane + LANE_IDX_W'(1);
    end else begin
      lane <= '0;
    end
  end

endmodule

// File: rtl/vec_mem_stage.sv
// Vector memory stage: serialises loads/stores over a byte-wide memory,
// one lane per cycle, and registers the completed bundle toward writeback.
module vec_mem_stage
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              regWriteE,
  input  logic              memToRegE,
  input  logic              memWriteE,
  input  logic              PCSrcE,
  input  logic [RA_W-1:0]   WA3E,
  input  logic [VEC_W-1:0]  aluResultE,
  input  logic [VEC_W-1:0]  writeDataE,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANE_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [LANE_W-1:0] mem_rdata,
  output logic              stallM,
  output logic              regWriteW,
  output logic              memToRegW,
  output logic              PCSrcW,
  output logic [RA_W-1:0]   WA3W,
  output logic [VEC_W-1:0]  aluResultW,
  output logic [VEC_W-1:0]  readDataW,
  output mem_state_t        dbg_state
);

  // Upstream handshake: the E bundle is consumed on every rising edge where
  // stallM is low; while stallM is high the E inputs are ignored and the
  // producer must hold its next instruction until stallM falls.

  mem_state_t state_q, state_d;

  logic                                cap_regw, cap_m2r, cap_pcs;
  logic [RA_W-1:0]                     cap_wa3;
  logic [VEC_W-1:0]                    cap_alu;
  logic [NLANES-1:0][LANE_W-1:0]       wdata_q;
  logic [NLANES-2:0][LANE_W-1:0]       rbuf_q;

  logic                  seq_step, seq_last;
  logic [LANE_IDX_W-1:0] lane;
  logic [ADDR_W-1:0]     seq_addr;

  lane_sequencer u_seq (
    .clk  (clk),
    .rst  (rst),
    .step (seq_step),
    .base (cap_alu[ADDR_W-1:0]),
    .lane (lane),
    .addr (seq_addr),
    .last (seq_last)
  );

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (memWriteE)      state_d = STORE;
        else if (memToRegE) state_d = LOAD;
      end
      STORE:     if (seq_last) state_d = IDLE;
      LOAD:      if (seq_last) state_d = LOAD_TAIL;
      LOAD_TAIL: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    stallM    = (state_q != IDLE);
    seq_step  = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      STORE: begin
        seq_step  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = seq_addr;
        mem_wdata = wdata_q[lane];
      end
      LOAD: begin
        seq_step = 1'b1;
        mem_re   = 1'b1;
        mem_addr = seq_addr;
      end
      default: ;
    endcase
  end

  // Captured bundle and load assembly buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_regw <= 1'b0;
      cap_m2r  <= 1'b0;
      cap_pcs  <= 1'b0;
      cap_wa3  <= '0;
      cap_alu  <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
    end else begin
      if (state_q == IDLE && (memWriteE || memToRegE)) begin
        cap_regw <= regWriteE;
        cap_m2r  <= memToRegE && !memWriteE;
        cap_pcs  <= PCSrcE;
        cap_wa3  <= WA3E;
        cap_alu  <= aluResultE;
        wdata_q  <= writeDataE;
      end
      // Read data lags the strobe by one cycle, so lane n lands while lane n+1 is addressed.
      if (state_q == LOAD && lane != '0) begin
        rbuf_q[lane - LANE_IDX_W'(1)] <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regWriteW  <= 1'b0;
      memToRegW  <= 1'b0;
      PCSrcW     <= 1'b0;
      WA3W       <= '0;
      aluResultW <= '0;
      readDataW  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (memWriteE || memToRegE) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            PCSrcW    <= 1'b0;
          end else begin
            regWriteW  <= regWriteE;
            memToRegW  <= 1'b0;
            PCSrcW     <= PCSrcE;
            WA3W       <= WA3E;
            aluResultW <= aluResultE;
            readDataW  <= '0;
          end
        end
        STORE: begin
          if (seq_last) begin
            regWriteW  <= cap_regw;
            memToRegW  <= 1'b0;
            PCSrcW     <= cap_pcs;
            WA3W       <= cap_wa3;
            aluResultW <= cap_alu;
            readDataW  <= '0;
          end
        end
        LOAD_TAIL: begin
          regWriteW  <= cap_regw;
          memToRegW  <= cap_m2r;
          PCSrcW     <= cap_pcs;
          WA3W       <= cap_wa3;
          aluResultW <= cap_alu;
          readDataW  <= {mem_rdata, rbuf_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_stage.sv
// Self-checking bench for vec_mem_stage with a byte memory and reference model.
module tb_vec_mem_stage;
  import vec_pkg::*;

  localparam int BW = 3 + RA_W + 2 * VEC_W;

  logic              clk, rst;
  logic              regWriteE, memToRegE, memWriteE, PCSrcE;
  logic [RA_W-1:0]   WA3E;
  logic [VEC_W-1:0]  aluResultE, writeDataE;
  logic [ADDR_W-1:0] mem_addr;
  logic [LANE_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we, mem_re, stallM;
  logic              regWriteW, memToRegW, PCSrcW;
  logic [RA_W-1:0]   WA3W;
  logic [VEC_W-1:0]  aluResultW, readDataW;
  mem_state_t        dbg_state;

  vec_mem_stage dut (
    .clk(clk), .rst(rst),
    .regWriteE(regWriteE), .memToRegE(memToRegE), .memWriteE(memWriteE), .PCSrcE(PCSrcE),
    .WA3E(WA3E), .aluResultE(aluResultE), .writeDataE(writeDataE),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .stallM(stallM),
    .regWriteW(regWriteW), .memToRegW(memToRegW), .PCSrcW(PCSrcW), .WA3W(WA3W),
    .aluResultW(aluResultW), .readDataW(readDataW), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- memory: DUT-facing and reference ----------------
  logic [7:0] sim_mem [0:65535];
  logic [7:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (mem_we) sim_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= sim_mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_w(input logic regw, input logic m2r, input logic pcs,
                                           input logic [RA_W-1:0] wa3,
                                           input logic [VEC_W-1:0] alu,
                                           input logic [VEC_W-1:0] rd);
    return {regw, m2r, pcs, wa3, alu, rd};
  endfunction

  typedef struct {
    logic             regw, m2r, mw, pcs;
    logic [RA_W-1:0]  wa3;
    logic [VEC_W-1:0] alu, wd;
    int               cyc;
  } vec_t;

  // ---------------- driver tasks ----------------
  task automatic drive_nop();
    regWriteE = 1'b0; memToRegE = 1'b0; memWriteE = 1'b0; PCSrcE = 1'b0;
    WA3E = '0; aluResultE = '0; writeDataE = '0;
  endtask

  task automatic drive_junk();
    regWriteE  = 1'($urandom_range(0, 1));
    memToRegE  = 1'($urandom_range(0, 1));
    memWriteE  = 1'($urandom_range(0, 1));
    PCSrcE     = 1'($urandom_range(0, 1));
    WA3E       = RA_W'($urandom_range(0, 15));
    aluResultE = VEC_W'({$urandom(), $urandom()});
    writeDataE = VEC_W'({$urandom(), $urandom()});
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge after writeback.
  task automatic issue(input vec_t v);
    logic [ADDR_W-1:0] base, a;
    logic [VEC_W-1:0]  rd;
    int cyc;
    base = v.alu[ADDR_W-1:0];
    rd = '0;
    cyc = 0;
    check("idle_mem_pins", 128'({mem_we, mem_re, mem_addr, mem_wdata}), 128'(0));
    regWriteE = v.regw; memToRegE = v.m2r; memWriteE = v.mw; PCSrcE = v.pcs;
    WA3E = v.wa3; aluResultE = v.alu; writeDataE = v.wd;
    if (v.mw) begin
      for (int i = 0; i < NLANES; i++) begin
        a = base + ADDR_W'(i);
        ref_mem[a] = v.wd[i*LANE_W +: LANE_W];
      end
      exp_q.push_back(pack_w(v.regw, 1'b0, v.pcs, v.wa3, v.alu, '0));
    end else if (v.m2r) begin
      for (int i = 0; i < NLANES; i++) begin
        a = base + ADDR_W'(i);
        rd[i*LANE_W +: LANE_W] = ref_mem[a];
      end
      exp_q.push_back(pack_w(v.regw, 1'b1, v.pcs, v.wa3, v.alu, rd));
    end else begin
      exp_q.push_back(pack_w(v.regw, 1'b0, v.pcs, v.wa3, v.alu, '0));
    end
    @(negedge clk);
    while (stallM && cyc < 20) begin
      check("wb_bubble", 128'({regWriteW, memToRegW, PCSrcW}), 128'(0));
      drive_junk();
      @(negedge clk);
      cyc++;
    end
    drive_nop();
    check("stall_cycles", 128'(cyc), 128'(v.cyc));
    if (exp_q.size() > 0)
      check("wb_bundle",
            128'({regWriteW, memToRegW, PCSrcW, WA3W, aluResultW, readDataW}),
            128'(exp_q.pop_front()));
    if (v.mw) begin
      for (int i = 0; i < NLANES; i++) begin
        a = base + ADDR_W'(i);
        check("mem_byte", 128'(sim_mem[a]), 128'(ref_mem[a]));
      end
    end
  endtask

  // ---------------- test ----------------
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 4'd5,  48'h0000_0000_00AB, 48'h0,            0};
    tbl[1]  = '{0, 0, 0, 1, 4'd9,  48'h1234_5678_9ABC, 48'hFFFF,         0};
    tbl[2]  = '{0, 0, 1, 0, 4'd0,  48'h0000_0000_0100, 48'h665544332211, 6};
    tbl[3]  = '{1, 1, 0, 0, 4'd3,  48'h0000_0000_0200, 48'h0,            7};
    tbl[4]  = '{0, 0, 1, 0, 4'd2,  48'hDEAD_0000_FFFE, 48'h0F0E0D0C0B0A, 6};
    tbl[5]  = '{1, 1, 0, 0, 4'd4,  48'h0000_0000_FFFE, 48'h0,            7};
    tbl[6]  = '{1, 0, 1, 1, 4'd7,  48'h0000_0000_0400, 48'hC6C5C4C3C2C1, 6};
    tbl[7]  = '{1, 1, 0, 0, 4'd8,  48'h0000_0000_0400, 48'h0,            7};
    tbl[8]  = '{1, 1, 1, 0, 4'd6,  48'h0000_0000_0500, 48'h112233445566, 6};
    tbl[9]  = '{1, 1, 0, 0, 4'd1,  48'h0000_0000_0500, 48'h0,            7};
    tbl[10] = '{1, 0, 0, 0, 4'd15, 48'hFFFF_FFFF_FFFF, 48'h0,            0};

    for (int i = 0; i < 65536; i++) begin
      sim_mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    for (int i = 0; i < NLANES; i++) begin
      sim_mem[16'h0200 + i] = 8'hA0 + 8'(i);
      ref_mem[16'h0200 + i] = 8'hA0 + 8'(i);
      sim_mem[16'h0300 + i] = 8'h5A;
      ref_mem[16'h0300 + i] = 8'h5A;
    end

    // Reset held with random inputs: everything stays at zero.
    rst = 1'b1;
    drive_nop();
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_junk();
      @(negedge clk);
      check("reset_outputs",
            128'({stallM, mem_we, mem_re, mem_addr, mem_wdata, regWriteW, memToRegW, PCSrcW,
                  WA3W, dbg_state}), 128'(0));
      check("reset_vectors", 128'({aluResultW, readDataW}), 128'(0));
    end
    drive_nop();
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) issue(tbl[i]);

    // Explicit spot checks of store placement, including the wrap past 0xFFFF.
    check("store_0105", 128'(sim_mem[16'h0105]), 128'(8'h66));
    check("store_0100", 128'(sim_mem[16'h0100]), 128'(8'h11));
    check("wrap_FFFF",  128'(sim_mem[16'hFFFF]), 128'(8'h0B));
    check("wrap_0000",  128'(sim_mem[16'h0000]), 128'(8'h0C));
    check("wrap_0003",  128'(sim_mem[16'h0003]), 128'(8'h0F));

    // Random ALU passthroughs.
    for (int k = 0; k < 8; k++) begin
      vec_t v;
      v.regw = 1'($urandom_range(0, 1));
      v.m2r  = 1'b0;
      v.mw   = 1'b0;
      v.pcs  = 1'($urandom_range(0, 1));
      v.wa3  = RA_W'($urandom_range(0, 15));
      v.alu  = VEC_W'({$urandom(), $urandom()});
      v.wd   = VEC_W'({$urandom(), $urandom()});
      v.cyc  = 0;
      issue(v);
    end

    // Reset asserted while the store drives lane 3: lanes 3..5 must stay untouched.
    check("pre_abort_idle", 128'(stallM), 128'(0));
    regWriteE = 1'b1; memWriteE = 1'b1; WA3E = 4'd11;
    aluResultE = 48'h0000_0000_0300; writeDataE = 48'hF6F5F4F3F2F1;
    for (int i = 0; i < 3; i++) ref_mem[16'h0300 + i] = 8'hF1 + 8'(i);
    @(negedge clk);
    drive_nop();
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("abort_lane3_addr", 128'({mem_we, mem_addr, mem_wdata}), 128'({1'b1, 16'h0303, 8'hF4}));
    rst = 1'b0;
    #1;
    check("abort_pins", 128'({mem_we, mem_re, stallM, mem_addr, mem_wdata}), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NLANES; i++)
      check("abort_mem", 128'(sim_mem[16'h0300 + i]), 128'(ref_mem[16'h0300 + i]));
    check("abort_tail_untouched", 128'(sim_mem[16'h0305]), 128'(8'h5A));

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
